// File: rtl/regfile_param.sv
// regfile_param: DATA_WIDTH x 2**ADDR_WIDTH register file with registered reads and a clear sweeper.
// Define REGFILE_BYPASS_EN to forward same-edge writes onto the read ports.
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_clear,
    output logic                  clear_busy,
    output logic                  write_dropped
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    typedef enum logic {IDLE, SWEEP} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_ok;
    logic [DATA_WIDTH-1:0] rd_a, rd_b;
    assign wr_ok = ctrl_writeEnable && !(ZERO_REG && ctrl_writeReg == '0);
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        rd_a = (ZERO_REG && ctrl_readRegA == '0) ? '0 :
               (state == IDLE && wr_ok && ctrl_writeReg == ctrl_readRegA) ? data_writeReg : mem[ctrl_readRegA];
        rd_b = (ZERO_REG && ctrl_readRegB == '0) ? '0 :
               (state == IDLE && wr_ok && ctrl_writeReg == ctrl_readRegB) ? data_writeReg : mem[ctrl_readRegB];
`else
        rd_a = (ZERO_REG && ctrl_readRegA == '0) ? '0 : mem[ctrl_readRegA];
        rd_b = (ZERO_REG && ctrl_readRegB == '0) ? '0 : mem[ctrl_readRegB];
`endif
    end
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state         <= IDLE;
            ptr           <= '0;
            clear_busy    <= 1'b0;
            write_dropped <= 1'b0;
            data_readRegA <= '0;
            data_readRegB <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            data_readRegA <= rd_a;
            data_readRegB <= rd_b;
            write_dropped <= state == SWEEP && wr_ok;
            if (state == IDLE) begin
                if (wr_ok) mem[ctrl_writeReg] <= data_writeReg;
                if (ctrl_clear) begin
                    state      <= SWEEP;
                    ptr        <= ADDR_WIDTH'(ZERO_REG);
                    clear_busy <= 1'b1;
                end
            end else begin
                mem[ptr] <= '0;
                ptr      <= ptr + 1'b1;
                // last entry zeroed: stop here rather than wrapping the pointer
                if (ptr == '1) begin
                    state      <= IDLE;
                    ptr        <= '0;
                    clear_busy <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed and random checks of regfile_param against an array-based reference model.
module tb_regfile_param;
    localparam int DEPTH    = 32;
    localparam bit ZERO_REG = 1;
    logic        clock = 0;
    logic        ctrl_reset = 1;
    logic        ctrl_writeEnable = 0;
    logic [4:0]  ctrl_writeReg = 0;
    logic [31:0] data_writeReg = 0;
    logic [4:0]  ctrl_readRegA = 0;
    logic [4:0]  ctrl_readRegB = 0;
    logic [31:0] data_readRegA, data_readRegB;
    logic        ctrl_clear = 0;
    logic        clear_busy, write_dropped;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] ref_mem [DEPTH];
    bit          sweeping = 0;
    int          sp = 0;

    regfile_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(ZERO_REG)) dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .ctrl_clear(ctrl_clear), .clear_busy(clear_busy), .write_dropped(write_dropped)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
        sweeping = 0;
        sp = 0;
    endtask

    // One clock: drive inputs, predict from the model's pre-edge view, then compare after the edge.
    task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic clr);
        logic [31:0] ea, eb;
        logic        ed;
        bit          ok;
        ctrl_writeEnable = we; ctrl_writeReg = wa; data_writeReg = wd;
        ctrl_readRegA = ra; ctrl_readRegB = rb; ctrl_clear = clr;
        ok = we && !(ZERO_REG && wa == 0);
        ea = (ZERO_REG && ra == 0) ? 32'h0 : ref_mem[ra];
        eb = (ZERO_REG && rb == 0) ? 32'h0 : ref_mem[rb];
`ifdef REGFILE_BYPASS_EN
        if (!sweeping && ok && wa == ra) ea = wd;
        if (!sweeping && ok && wa == rb) eb = wd;
`endif
        ed = 0;
        if (!sweeping) begin
            if (ok) ref_mem[wa] = wd;
            if (clr) begin
                sweeping = 1;
                sp = ZERO_REG ? 1 : 0;
            end
        end else begin
            ref_mem[sp] = 0;
            ed = ok;
            sp++;
            if (sp == DEPTH) sweeping = 0;
        end
        @(posedge clock);
        #1;
        chk("rdA", data_readRegA, ea);
        chk("rdB", data_readRegB, eb);
        chk("busy", {31'b0, clear_busy}, {31'b0, sweeping});
        chk("drop", {31'b0, write_dropped}, {31'b0, ed});
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 5'($urandom), 5'($urandom), 0);
    endtask

    task automatic fill();
        for (int i = 1; i < DEPTH; i++) cyc(1, 5'(i), $urandom | 32'h1, 5'(i - 1), 5'(i), 0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i += 2) cyc(0, 0, 0, 5'(i), 5'(i + 1), 0);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_rdA", data_readRegA, 0);
        chk("rst_rdB", data_readRegB, 0);
        chk("rst_busy", {31'b0, clear_busy}, 0);
        chk("rst_drop", {31'b0, write_dropped}, 0);
        ctrl_reset = 0;

        cyc(0, 0, 0, 3, 31, 0);
        cyc(1, 7, 32'hDEADBEEF, 0, 0, 0);
        cyc(0, 0, 0, 7, 7, 0);
        chk("r7", data_readRegA, 32'hDEADBEEF);
        cyc(1, 0, 32'h1234, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("r0", data_readRegA, 0);

        cyc(1, 9, 32'h11, 0, 0, 0);
        cyc(1, 9, 32'hA5A5A5A5, 9, 9, 0);
`ifdef REGFILE_BYPASS_EN
        chk("same_edge", data_readRegA, 32'hA5A5A5A5);
`else
        chk("same_edge", data_readRegA, 32'h11);
`endif
        cyc(0, 0, 0, 9, 9, 0);
        chk("r9_next", data_readRegA, 32'hA5A5A5A5);

        for (int i = 0; i < 200; i++) cyc($urandom_range(0, 1), 5'($urandom), $urandom, 5'($urandom), 5'($urandom), 0);

        // full sweep with a mid-sweep re-clear and a dropped write to r5
        fill();
        cyc(0, 0, 0, 1, 2, 1);
        n = 0;
        do begin
            if (n == 10) cyc(0, 0, 0, 5'($urandom), 5'($urandom), 1);
            else if (n == 12) cyc(1, 5, 32'h77, 5, 13, 0);
            else idle_cyc();
            n++;
        end while (clear_busy && n < 100);
        chk("busy_len", n, ZERO_REG ? DEPTH - 1 : DEPTH);
        read_all();
        cyc(0, 0, 0, 5, 5, 0);
        chk("r5_after", data_readRegA, 0);

        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 1), 5'($urandom), $urandom, 5'($urandom), 5'($urandom), $urandom_range(0, 40) == 0);
        n = 0;
        while (sweeping && n < 100) begin
            idle_cyc();
            n++;
        end

        // async reset with the sweep pointer at entry 10
        fill();
        cyc(0, 0, 0, 3, 4, 1);
        n = 0;
        while (sp != 10 && n < 40) begin
            cyc(0, 0, 0, 20, 30, 0);
            n++;
        end
        chk("sp_reach", sp, 10);
        #1 ctrl_reset = 1;
        #1;
        chk("arst_rdA", data_readRegA, 0);
        chk("arst_rdB", data_readRegB, 0);
        chk("arst_busy", {31'b0, clear_busy}, 0);
        chk("arst_drop", {31'b0, write_dropped}, 0);
        model_reset();
        #1 ctrl_reset = 0;
        cyc(1, 12, 32'hCAFEF00D, 12, 0, 0);
        cyc(0, 0, 0, 12, 12, 0);
        chk("r12", data_readRegB, 32'hCAFEF00D);
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the 32x32 register file: DATA_WIDTH x 2**ADDR_WIDTH storage, one write port, two registered read ports. Adds a hardwired-zero register option, one-cycle registered reads, and a hardware clear sequencer that zeroes the array one entry per cycle without a global reset. Sits in the processor datapath between decode (read addresses) and writeback (write port).

Parameters:
DATA_WIDTH, 32, width of each register and of all data ports
ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries (derived, not overridable)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is ordinary storage

Ports:
clock  in  1  single clock; all state updates on rising edge
ctrl_reset  in  1  asynchronous, active-high reset
ctrl_writeEnable  in  1  write request this cycle
ctrl_writeReg  in  ADDR_WIDTH  write address
data_writeReg  in  DATA_WIDTH  write data
ctrl_readRegA  in  ADDR_WIDTH  read address, port A
ctrl_readRegB  in  ADDR_WIDTH  read address, port B
data_readRegA  out  DATA_WIDTH  registered read data, port A
data_readRegB  out  DATA_WIDTH  registered read data, port B
ctrl_clear  in  1  start array clear sweep (sampled in IDLE only)
clear_busy  out  1  high while sweep in progress
write_dropped  out  1  one-cycle pulse: a write was discarded due to sweep

Behaviour:
- Reset (async, any time incl. mid-sweep): all entries 0, data_readRegA/B = 0, clear_busy = 0, write_dropped = 0, FSM = IDLE, sweep pointer = 0.
- Reads: address sampled at edge N, data on data_readRegX after edge N (latency 1). Both ports independent; same address on both allowed.
- ZERO_REG=1: read of address 0 always yields 0; write to address 0 silently ignored (write_dropped not asserted).
- Write: ctrl_writeEnable=1 at edge N updates entry at edge N; in IDLE only.
- Read/write same address same edge, no bypass: read returns the pre-write value.
- FSM IDLE: ctrl_clear=1 -> SWEEP, pointer = ZERO_REG ? 1 : 0. clear_busy rises the cycle after ctrl_clear is sampled.
- FSM SWEEP: each edge writes 0 to entry[pointer], pointer++. After entry DEPTH-1 is written -> IDLE, clear_busy falls. Sweep length: DEPTH-1 cycles (ZERO_REG=1) or DEPTH cycles (ZERO_REG=0).
- ctrl_clear during SWEEP: ignored, no restart.
- Port write during SWEEP: discarded, write_dropped = 1 on the following cycle (one cycle per dropped write, back-to-back pulses allowed).
- Reads during SWEEP permitted: return current array contents; a read of entry[pointer] on the edge it is zeroed returns the pre-clear value.
- Pointer is ADDR_WIDTH bits; no wrap beyond DEPTH-1 (terminates sweep).

Optional Feature:
REGFILE_BYPASS_EN: defined -> write-through forwarding: in IDLE, if ctrl_writeEnable=1 and ctrl_writeReg equals ctrl_readRegX (and not the zero register when ZERO_REG=1), data_readRegX takes data_writeReg at that edge. Sweep zeroing is never forwarded. Undefined -> no forwarding; same-edge read returns old value.

Test Plan:
Reset then read A=3, B=31 -> both outputs 0 one cycle later; clear_busy=0, write_dropped=0.
Write 0xDEADBEEF to r7, next cycle read A=7 -> data_readRegA=0xDEADBEEF after 1 cycle; write 0x1234 to r0 (ZERO_REG=1), read r0 -> 0.
Same-edge write 0xA5A5A5A5 to r9 and read A=9 (r9 held 0x11) -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x11 without; next read -> 0xA5A5A5A5 both.
Fill r1..r31 nonzero, pulse ctrl_clear -> clear_busy high exactly 31 cycles (32 with ZERO_REG=0); afterwards all reads 0; ctrl_clear re-pulsed mid-sweep does not extend busy.
Write r5=0x77 during SWEEP -> write_dropped pulses 1 cycle, r5 reads 0 after sweep.
Assert ctrl_reset mid-sweep (pointer=10) -> clear_busy=0 and outputs 0 immediately; all entries 0; new write/read to r12 works next cycle.
